otter_fetch_unit: RTL and testbench
===================================

// Module: otter_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the pipelined OTTER MCU: owns the fetch PC and drives memory port 1.
//  Buffers returned instructions in a small queue and feeds decode through a valid/ready handshake.
//  Decode's IF_ID_Write drives ID_READY. Execute's taken branch/jump drives REDIRECT/REDIRECT_PC.
//  Replaces the free-running PC + PC_MUX + IF/ID register and makes stalls and flushes lossless.
// PARAMETERS
//  RESET_VEC  32'h0000_0000  first fetch address after reset (word aligned)
//  DEPTH      2              instruction queue entries; power of two, >=2
// PORTS
//  CLOCK        in   1   single clock; all state updates on posedge
//  RESET        in   1   synchronous, active-low reset
//  MEM_ADDR1    out  14  word address to memory port 1 = fetch PC[15:2]
//  MEM_RDEN1    out  1   fetch request; MEM_DOUT1 is valid exactly 1 cycle later
//  MEM_DOUT1    in   32  instruction word returned for the previous cycle's request
//  ID_READY     in   1   decode accepts head instruction this cycle (IF_ID_Write)
//  REDIRECT     in   1   flush and restart fetch at REDIRECT_PC
//  REDIRECT_PC  in   32  new fetch address; bits [1:0] are ignored (forced to 0)
//  IF_VALID     out  1   IF_IR/IF_PC/IF_PC_4 hold a valid instruction
//  IF_IR        out  32  instruction; 32'h0000_0013 (NOP) whenever IF_VALID=0
//  IF_PC        out  32  address of IF_IR; 0 when IF_VALID=0
//  IF_PC_4      out  32  IF_PC+4 (mod 2^32); 0 when IF_VALID=0
// BEHAVIOUR
//  Reset (RESET=0 at posedge):
//   - fpc=RESET_VEC, queue count=0, in-flight flag=0
//   - outputs IF_VALID=0, IF_IR=NOP, IF_PC=0, IF_PC_4=0, MEM_RDEN1=0 during the reset cycle
//   - reset mid-operation discards queue contents and in-flight data
//  Issue:
//   - MEM_RDEN1=1 when (count + inflight - pop) < DEPTH and REDIRECT=0
//   - MEM_ADDR1=fpc[15:2]; on issue fpc<=fpc+4 and inflight<=1, also latch fpc as inflight_pc
//   - fpc wraps mod 2^32; the memory address therefore wraps at 64 KiB
//   - the first issue occurs in the first cycle after RESET returns high
//  Response (inflight=1):
//   - push {MEM_DOUT1, inflight_pc} into the queue tail
//   - no push in cycles where the same-cycle bypass consumes the response (see CONFIGURATION)
//  Pop:
//   - pop = IF_VALID & ID_READY; the head advances at posedge
//   - outputs are driven from the head register (no combinational path from ID_READY to IF_*)
//  Stall (ID_READY=0):
//   - IF_* hold stable
//   - queue fills to DEPTH, then MEM_RDEN1 deasserts; no instruction lost or duplicated
//  Redirect (REDIRECT=1), priority over push/pop/issue:
//   - count<=0; the in-flight response arriving next cycle is discarded via an epoch bit
//   - fpc<=REDIRECT_PC & ~3; MEM_RDEN1=0 in the redirect cycle; fetch resumes next cycle
//   - IF_VALID=0 in the cycle after REDIRECT
//   - REDIRECT in the same cycle as a response drops that response
//  Throughput: one instruction per cycle sustained with ID_READY=1
//  Queue pointers wrap mod DEPTH; count is never >DEPTH and never <0
// CONFIGURATION
//  FETCH_BYPASS_EN defined:
//   - when count=0 and a valid response arrives, IF_* present MEM_DOUT1/inflight_pc the same cycle
//   - the response is pushed only if ID_READY=0
//   - issue-to-IF_VALID latency is 1 cycle
//  FETCH_BYPASS_EN undefined:
//   - every response passes through the queue
//   - issue-to-IF_VALID latency is 2 cycles; all outputs are fully registered
// TESTING
//  1 Release reset, ID_READY=1, memory word[n]=n -> MEM_ADDR1 0,1,2..;
//    IF_VALID first at cycle 2 (1 with bypass); IF_PC 0,4,8 every cycle
//  2 ID_READY=0 for 6 cycles with IF_PC=0x8 at head -> MEM_RDEN1 low after queue full, IF_PC held 0x8;
//    release -> 0x8,0xC,0x10 with no gap or duplicate
//  3 Queue full + in-flight, REDIRECT_PC=0x100 -> next valid IF_PC=0x100, IF_PC_4=0x104, no stale instruction
//  4 REDIRECT_PC=0x102 -> fetch at MEM_ADDR1=0x40, IF_PC=0x100
//  5 REDIRECT in the same cycle as a response -> response dropped; following IF_VALID only for redirect target
//  6 RESET=0 one cycle mid-stream -> IF_VALID=0 next cycle; fetch restarts at RESET_VEC; fpc=0xFFFC wraps to MEM_ADDR1=0

Source files
------------

// File: rtl/otter_fetch_unit.sv
// OTTER instruction-fetch stage: fetch PC, memory port 1 requests, small instruction queue, valid/ready to decode.
// Optional macro FETCH_BYPASS_EN presents a response straight to IF_* when the queue is empty.
module otter_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  output logic [13:0] MEM_ADDR1,
  output logic        MEM_RDEN1,
  input  logic [31:0] MEM_DOUT1,
  input  logic        ID_READY,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IF_VALID,
  output logic [31:0] IF_IR,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC_4
);

  localparam int          CW  = $clog2(DEPTH + 1);
  localparam int          PW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fpc_reg;
  logic [31:0]   inflight_pc_reg;
  logic          inflight_reg;
  logic          inflight_epoch_reg;
  logic          epoch_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [31:0]   q_ir [DEPTH];
  logic [31:0]   q_pc [DEPTH];

  logic          resp_valid;
  logic          head_valid;
  logic          push;
  logic          pop;
  logic          pop_q;
  logic          issue;
  logic [CW:0]   occupancy;
  logic          out_valid;
  logic [31:0]   out_ir;
  logic [31:0]   out_pc;

  // A response is usable only if it belongs to the current epoch and is not being flushed.
  assign resp_valid = inflight_reg && (inflight_epoch_reg == epoch_reg) && !REDIRECT;
  assign head_valid = (count_reg != '0);

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = !head_valid && resp_valid;
  assign push      = resp_valid && !(bypass && ID_READY);
  assign out_valid = head_valid || bypass;
  assign out_ir    = head_valid ? q_ir[head_reg] : MEM_DOUT1;
  assign out_pc    = head_valid ? q_pc[head_reg] : inflight_pc_reg;
`else
  assign push      = resp_valid;
  assign out_valid = head_valid;
  assign out_ir    = q_ir[head_reg];
  assign out_pc    = q_pc[head_reg];
`endif

  assign IF_VALID = RESET && out_valid;
  assign IF_IR    = IF_VALID ? out_ir : NOP;
  assign IF_PC    = IF_VALID ? out_pc : 32'h0;
  assign IF_PC_4  = IF_VALID ? (out_pc + 32'd4) : 32'h0;

  assign pop   = IF_VALID && ID_READY;
  assign pop_q = pop && head_valid;

  // Slots already claimed after this cycle's pop; a new request must still have room to land.
  assign occupancy = {1'b0, count_reg} + (CW + 1)'(inflight_reg) - (CW + 1)'(pop);
  assign issue     = RESET && !REDIRECT && (occupancy < (CW + 1)'(DEPTH));

  assign MEM_RDEN1 = issue;
  assign MEM_ADDR1 = fpc_reg[15:2];

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      fpc_reg      <= RESET_VEC;
      inflight_reg <= 1'b0;
      epoch_reg    <= 1'b0;
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else if (REDIRECT) begin
      fpc_reg      <= REDIRECT_PC & ~32'd3;
      inflight_reg <= 1'b0;
      epoch_reg    <= ~epoch_reg;
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      if (issue) begin
        fpc_reg            <= fpc_reg + 32'd4;
        inflight_pc_reg    <= fpc_reg;
        inflight_epoch_reg <= epoch_reg;
      end
      inflight_reg <= issue;
      if (push)  tail_reg <= tail_reg + PW'(1);
      if (pop_q) head_reg <= head_reg + PW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop_q);
    end
  end

  // Queue storage has no reset; count_reg alone says which entries are live.
  always_ff @(posedge CLOCK) begin
    if (RESET && push) begin
      q_ir[tail_reg] <= MEM_DOUT1;
      q_pc[tail_reg] <= inflight_pc_reg;
    end
  end

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Directed bench for otter_fetch_unit with an issue-order scoreboard; honours FETCH_BYPASS_EN.
module tb_otter_fetch_unit;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] mem_addr;
  logic        mem_rden;
  logic [31:0] mem_dout = 32'hDEAD_BEEF;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;

  otter_fetch_unit #(.RESET_VEC(RESET_VEC), .DEPTH(2)) dut (
    .CLOCK(clk), .RESET(rst_n),
    .MEM_ADDR1(mem_addr), .MEM_RDEN1(mem_rden), .MEM_DOUT1(mem_dout),
    .ID_READY(id_ready), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
    .IF_VALID(if_valid), .IF_IR(if_ir), .IF_PC(if_pc), .IF_PC_4(if_pc_4)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pops = 0;
  int          n_valid = 0;
  logic [31:0] sb[$];
  logic [31:0] model_pc = RESET_VEC;
  logic        obs_rd;
  logic [13:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_pc;
  bit          got_first = 0;
  logic [31:0] first_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs, score them, let the edge pass, then answer the memory request.
  task automatic tick();
    logic [31:0] exp;
    #1;
    obs_rd    = mem_rden;
    obs_addr  = mem_addr;
    obs_valid = if_valid;
    obs_pc    = if_pc;
    if (!rst_n) check("rst_valid", 32'(if_valid), 0);
    if (!rst_n || redirect) check("rden_blocked", 32'(mem_rden), 0);
    if (mem_rden === 1'b1) begin
      check("issue_addr", {18'b0, mem_addr}, {18'b0, model_pc[15:2]});
      sb.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
    if (if_valid === 1'b1) begin
      n_valid++;
      if (!got_first) begin
        got_first = 1;
        first_pc  = if_pc;
      end
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp = sb[0];
        check("if_pc", if_pc, exp);
        check("if_ir", if_ir, {18'b0, exp[15:2]});
        check("if_pc_4", if_pc_4, exp + 32'd4);
        if (id_ready) begin
          void'(sb.pop_front());
          n_pops++;
        end
      end
    end else begin
      check("idle_ir", if_ir, NOP);
      check("idle_pc", if_pc, 32'h0);
      check("idle_pc_4", if_pc_4, 32'h0);
    end
    @(posedge clk);
    #1;
    mem_dout = (obs_rd === 1'b1) ? {18'b0, obs_addr} : 32'hDEAD_BEEF;
    if (!rst_n) begin
      sb.delete();
      model_pc = RESET_VEC;
    end else if (redirect) begin
      sb.delete();
      model_pc = redirect_pc & ~32'd3;
    end
    $display("tick: rd=%b addr=%h valid=%b pc=%h ready=%b redirect=%b rst_n=%b",
             obs_rd, obs_addr, obs_valid, obs_pc, id_ready, redirect, rst_n);
  endtask

  task automatic run_until_first(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !got_first; i++) tick();
    check({"reach_", tag}, 32'(got_first), 1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect  = 1'b0;
    got_first = 0;
  endtask

  initial begin
    int first_c;
    @(posedge clk);
    #1;
    // Reset held for two cycles
    repeat (2) tick();

    // 1: stream from reset, latency and throughput
    rst_n = 1'b1;
    id_ready = 1'b1;
    first_c = -1;
    n_valid = 0;
    got_first = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) check("first_issue", 32'(obs_rd), 1);
      if (obs_valid === 1'b1 && first_c < 0) first_c = c;
    end
    check("latency", 32'(first_c), 32'(LAT));
    check("throughput", 32'(n_valid), 32'(10 - LAT));

    // 2: stall with 0x8 at head, then release
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_pops = 0;
    for (int i = 0; i < 12 && n_pops < 2; i++) tick();
    check("pre_stall_pops", 32'(n_pops), 2);
    id_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_pc_held", obs_pc, 32'h8);
    end
    check("stall_rden_low", 32'(obs_rd), 0);
    id_ready = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 6; i++) tick();
    check("release_no_gap", 32'(n_valid), 6);

    // 3: queue full plus in-flight, then redirect
    id_ready = 1'b0;
    tick();
    do_redirect(32'h0000_0100);
    tick();
    check("post_redirect_valid", 32'(obs_valid), 0);
    check("post_redirect_rden", 32'(obs_rd), 1);
    id_ready = 1'b1;
    run_until_first("t3", 6);
    check("t3_first_pc", first_pc, 32'h100);
    repeat (3) tick();

    // 4: misaligned redirect target
    do_redirect(32'h0000_0102);
    tick();
    check("t4_addr", {18'b0, obs_addr}, 32'h40);
    run_until_first("t4", 6);
    check("t4_first_pc", first_pc, 32'h100);
    repeat (3) tick();

    // 5: redirect in the same cycle a response returns
    check("t5_inflight", 32'(obs_rd), 1);
    do_redirect(32'h0000_0200);
    tick();
    check("t5_post_valid", 32'(obs_valid), 0);
    run_until_first("t5", 6);
    check("t5_first_pc", first_pc, 32'h200);
    repeat (2) tick();

    // 6: one-cycle reset mid-stream, then address wrap cases
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    got_first = 0;
    tick();
    check("t6_post_reset_valid", 32'(obs_valid), 0);
    check("t6_restart_addr", {18'b0, obs_addr}, {18'b0, RESET_VEC[15:2]});
    run_until_first("t6", 6);
    check("t6_first_pc", first_pc, RESET_VEC);
    repeat (2) tick();
    do_redirect(32'h0000_FFFC);
    tick();
    check("wrap_addr_hi", {18'b0, obs_addr}, 32'h3FFF);
    tick();
    check("wrap_addr_lo", {18'b0, obs_addr}, 32'h0);
    run_until_first("t6w", 6);
    check("wrap_first_pc", first_pc, 32'h0000_FFFC);
    repeat (3) tick();
    do_redirect(32'hFFFF_FFFC);
    run_until_first("t6top", 6);
    check("top_first_pc", first_pc, 32'hFFFF_FFFC);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected completion");
    $fatal(1, "watchdog");
  end

endmodule
